input_capture: RTL and testbench
================================

# input_capture

Input-side peripheral for the single-cycle CPU's memory-mapped I/O window. It synchronizes and debounces the active-low push buttons, synchronizes the slide switches, and latches press events in sticky, read-to-clear flags. It drives read data onto the CPU data path through the existing tri-state transceiver. It sits beside the LED output registers and decodes the same 16-bit address bus, returning data on reads where the LED path accepts writes.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized cycles required to accept a button level change (≥2).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  16  CPU address.
- oe  in  1  CPU access direction; 0 = read (load), 1 = write (store).
- buttons  in  4  raw board keys, active-low, asynchronous.
- switches  in  9  raw board switches, active-high, asynchronous.
- data_io  out  16  read data toward the transceiver.
- le  out  1  transceiver enable; 1 while a decoded read is in progress.
- irq  out  1  1 while any event flag is set.

## Operation
- Address map (read only): 16'hFFFD = debounced buttons {12'b0, btn_db[3:0]}; 16'hFFFC = switches {7'b0, sw_sync[8:0]}; 16'hFFFB = event flags {12'b0, evt[3:0]}.
- Synchronizers: two flops per button and per switch. Buttons are inverted after the second flop, so pressed = 1.
- Debounce, per button: a stable register btn_db holds the accepted level and a counter cnt tracks candidate changes.
  - While the sample equals btn_db: cnt = 0.
  - While the sample differs from btn_db: cnt increments.
  - When cnt reaches DEBOUNCE_CYCLES-1 and the sample still differs: btn_db takes the sample and cnt = 0.
  - A single glitch cycle resets the count.
- Event flag evt[i] sets in the cycle btn_db[i] goes 0→1. Releases set no flag.
- Read decode is combinational:
  - le = (~oe) & (addr ∈ {FFFB, FFFC, FFFD}).
  - data_io is the selected word when le = 1, otherwise 16'h0000.
- Read-to-clear: on a clock edge with ~oe & addr==FFFB, evt clears to 0. If a new rising edge on bit i coincides with the clear, that bit stays 1 (set wins). Other bits clear.
- Writes (oe = 1) to any of the three addresses have no effect and le = 0.
- irq = |evt, driven from registers.

## Timing
- Reset (reset = 0, asynchronous): synchronizer flops = idle level (buttons 1, switches 0); btn_db = 0; cnt = 0; evt = 0; irq = 0. data_io = 0 and le = 0 unless a read is decoded.
- Release of reset is taken on the next rising edge. Reset asserted mid-debounce discards the partial count.
- Switch latency: 2 cycles from input change to readable value.
- Button press latency: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles to btn_db. evt and irq follow on the same edge btn_db changes.
- Read data is valid combinationally in the same cycle addr/oe are presented. The clear takes effect at the end of that cycle, so the read returns the pre-clear value.
- Counter saturation is impossible: cnt resets on acceptance and never exceeds DEBOUNCE_CYCLES-1.

## Structure
- Shared include io_defs.vh: ADDR_EVT = 16'hFFFB, ADDR_SW = 16'hFFFC, ADDR_BTN = 16'hFFFD. It also keeps the existing LED addresses FFFE/FFFF so all decoders use one map.
- Sub-module debouncer (parameters DEBOUNCE_CYCLES, CNT_W): ports clk, reset, sample, stable, rise. Instantiate 4 times.
- Top level holds the synchronizers, the evt register, the decode mux and the irq OR.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES = 4.
- Reset: hold reset = 0 with buttons = 4'b0000 → data_io = 0 at FFFD, irq = 0, evt = 0. After release, btn_db reaches 4'hF only after 2+4 cycles.
- Clean press on key 1: buttons = 4'b1101 held → FFFD reads 16'h0002 exactly 6 cycles later; irq = 1 the same cycle; FFFB reads 16'h0002.
- Bounce: toggle buttons[0] every 2 cycles for 20 cycles, then release → btn_db[0] never changes, evt = 0, irq = 0.
- Read-to-clear and simultaneous set:
  - Read FFFB → returns 16'h0002, next cycle evt = 0 and irq = 0.
  - With key 2's btn_db rising on the same edge as the clear: evt = 16'h0004 afterwards.
- Switches and direction: switches = 9'h1A5 → FFFC reads 16'h01A5 after 2 cycles. oe = 1 at FFFC → le = 0, data_io = 0. addr = 16'h1234 with oe = 0 → le = 0.
- Mid-debounce reset: assert reset after 3 stable cycles of a press → btn_db stays 0. After release of reset, a full 2+4 cycles are needed again.

Source files
------------

// File: rtl/input_capture_pkg.sv
// Shared I/O address map and read-select decode for the memory-mapped I/O window.
package input_capture_pkg;

  // Input-side read addresses
  localparam logic [15:0] ADDR_EVT  = 16'hFFFB;
  localparam logic [15:0] ADDR_SW   = 16'hFFFC;
  localparam logic [15:0] ADDR_BTN  = 16'hFFFD;
  // LED output registers decoded by the output path; kept here so all decoders share one map
  localparam logic [15:0] ADDR_LED0 = 16'hFFFE;
  localparam logic [15:0] ADDR_LED1 = 16'hFFFF;

  localparam int unsigned N_BTN = 4;
  localparam int unsigned N_SW  = 9;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_EVT,
    SEL_SW,
    SEL_BTN
  } rd_sel_e;

  // Selects the read source; stores (oe = 1) never select anything
  function automatic rd_sel_e decode_rd(input logic [15:0] a, input logic oe);
    rd_sel_e sel;
    sel = SEL_NONE;
    if (!oe) begin
      case (a)
        ADDR_EVT: sel = SEL_EVT;
        ADDR_SW:  sel = SEL_SW;
        ADDR_BTN: sel = SEL_BTN;
        default:  sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/input_capture_debouncer.sv
// Single-key debouncer: accepts a level change only after DEBOUNCE_CYCLES
// consecutive cycles of a differing synchronized sample.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             w_diff;
  logic             w_accept;

  assign w_diff   = sample ^ r_stable;
  assign w_accept = w_diff & (r_cnt == LAST);

  // Count consecutive differing samples; any agreeing sample restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!w_diff) begin
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_stable <= sample;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign stable = r_stable;
  // Combinational so the event flag sets on the same edge the stable level rises
  assign rise   = w_accept & sample;

endmodule

// File: rtl/input_capture.sv
// Button/switch input capture for the CPU I/O window: synchronizers, debouncers,
// sticky read-to-clear press flags and the combinational read mux.
module input_capture
  import input_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        oe,
  input  logic [3:0]  buttons,
  input  logic [8:0]  switches,
  output logic [15:0] data_io,
  output logic        le,
  output logic        irq
);

  logic [N_BTN-1:0] r_btn_s1;
  logic [N_BTN-1:0] r_btn_s2;
  logic [N_SW-1:0]  r_sw_s1;
  logic [N_SW-1:0]  r_sw_s2;
  logic [N_BTN-1:0] r_evt;
  logic             r_irq;

  logic [N_BTN-1:0] w_sample;
  logic [N_BTN-1:0] w_btn_db;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_evt_next;
  logic             w_rd_evt;
  rd_sel_e          w_sel;

  // Two-flop synchronizers, reset to the idle board levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_s1 <= '1;
      r_btn_s2 <= '1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= buttons;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= switches;
      r_sw_s2  <= r_sw_s1;
    end
  end

  assign w_sample = ~r_btn_s2;

  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .sample(w_sample[g]),
      .stable(w_btn_db[g]),
      .rise  (w_rise[g])
    );
  end

  assign w_sel    = decode_rd(addr, oe);
  assign w_rd_evt = (w_sel == SEL_EVT);

  // Next event flags: a flag read clears, a coincident press sets (set wins)
  always_comb begin
    w_evt_next = r_evt;
    if (w_rd_evt) begin
      w_evt_next = '0;
    end
    w_evt_next = w_evt_next | w_rise;
  end

  // Sticky event flags and registered interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_evt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_evt <= w_evt_next;
      r_irq <= |w_evt_next;
    end
  end

  assign irq = r_irq;

  // Combinational read mux toward the transceiver
  always_comb begin
    data_io = '0;
    le      = 1'b0;
    case (w_sel)
      SEL_EVT: begin
        le      = 1'b1;
        data_io = {12'b0, r_evt};
      end
      SEL_SW: begin
        le      = 1'b1;
        data_io = {7'b0, r_sw_s2};
      end
      SEL_BTN: begin
        le      = 1'b1;
        data_io = {12'b0, w_btn_db};
      end
      default: begin
        le      = 1'b0;
        data_io = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture with DEBOUNCE_CYCLES = 4 and a queue scoreboard.
module tb_input_capture;

  localparam logic [15:0] A_EVT = 16'hFFFB;
  localparam logic [15:0] A_SW  = 16'hFFFC;
  localparam logic [15:0] A_BTN = 16'hFFFD;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic        oe;
  logic [3:0]  buttons;
  logic [8:0]  switches;
  logic [15:0] data_io;
  logic        le;
  logic        irq;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  input_capture #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .oe      (oe),
    .buttons (buttons),
    .switches(switches),
    .data_io (data_io),
    .le      (le),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [15:0] o);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %h required <queued expectation>", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %h required %h", e.tag, o, e.val);
      end
    end
  endtask

  // Read between clock edges and return to idle before the next edge
  task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic l);
    oe   = 1'b0;
    addr = a;
    #1;
    d    = data_io;
    l    = le;
    oe   = 1'b1;
    addr = 16'h0000;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] v);
    logic [15:0] d;
    logic        l;
    expect_val(tag, v);
    rd(a, d, l);
    observe(d);
  endtask

  task automatic irqchk(input string tag, input logic v);
    expect_val(tag, {15'b0, v});
    observe({15'b0, irq});
  endtask

  // Read the event register across a clock edge so the clear takes effect
  task automatic rd_clear(input string tag, input logic [15:0] v);
    expect_val(tag, v);
    oe   = 1'b0;
    addr = A_EVT;
    #1;
    observe(data_io);
    cyc(1);
    oe   = 1'b1;
    addr = 16'h0000;
  endtask

  initial begin
    logic [15:0] d;
    logic        l;

    reset    = 1'b0;
    buttons  = 4'b0000;
    switches = 9'h000;
    oe       = 1'b1;
    addr     = 16'h0000;
    cyc(3);

    // Reset state with all keys held
    rdchk("rst_btn", A_BTN, 16'h0000);
    expect_val("rst_le_btn", 16'h0001);
    rd(A_BTN, d, l);
    observe({15'b0, l});
    irqchk("rst_irq", 1'b0);
    rdchk("rst_evt", A_EVT, 16'h0000);
    rdchk("rst_sw", A_SW, 16'h0000);

    // Release reset: all keys accepted after 2+4 cycles
    reset = 1'b1;
    expect_val("rel_btn_early", 16'h0000);
    cyc(5);
    rd(A_BTN, d, l);
    observe(d);
    expect_val("rel_btn_6", 16'h000F);
    cyc(1);
    rd(A_BTN, d, l);
    observe(d);
    irqchk("rel_irq", 1'b1);
    rdchk("rel_evt", A_EVT, 16'h000F);

    // Release all keys; releases set no flag, then clear
    buttons = 4'b1111;
    cyc(8);
    rdchk("relall_btn", A_BTN, 16'h0000);
    rdchk("relall_evt", A_EVT, 16'h000F);
    rd_clear("clr0_data", 16'h000F);
    rdchk("clr0_evt", A_EVT, 16'h0000);
    irqchk("clr0_irq", 1'b0);

    // Clean press on key 1
    buttons = 4'b1101;
    expect_val("k1_btn_5", 16'h0000);
    cyc(5);
    rd(A_BTN, d, l);
    observe(d);
    irqchk("k1_irq_5", 1'b0);
    expect_val("k1_btn_6", 16'h0002);
    cyc(1);
    rd(A_BTN, d, l);
    observe(d);
    irqchk("k1_irq_6", 1'b1);
    rdchk("k1_evt", A_EVT, 16'h0002);

    // Read-to-clear returns the pre-clear value
    expect_val("clr1_le", 16'h0001);
    oe   = 1'b0;
    addr = A_EVT;
    #1;
    observe({15'b0, le});
    oe   = 1'b1;
    addr = 16'h0000;
    rd_clear("clr1_data", 16'h0002);
    rdchk("clr1_evt", A_EVT, 16'h0000);
    irqchk("clr1_irq", 1'b0);

    // Key 3 event, then key 2 rises on the same edge as a clear
    buttons = 4'b0101;
    cyc(6);
    rdchk("k3_evt", A_EVT, 16'h0008);
    rdchk("k3_btn", A_BTN, 16'h000A);
    buttons = 4'b0001;
    cyc(5);
    rd_clear("sim_data", 16'h0008);
    rdchk("sim_evt", A_EVT, 16'h0004);
    rdchk("sim_btn", A_BTN, 16'h000E);
    irqchk("sim_irq", 1'b1);

    // Store to the event address neither decodes nor clears
    expect_val("wr_le", 16'h0000);
    oe   = 1'b1;
    addr = A_EVT;
    #1;
    observe({15'b0, le});
    cyc(1);
    addr = 16'h0000;
    rdchk("wr_evt", A_EVT, 16'h0004);

    // Release all and clear
    buttons = 4'b1111;
    cyc(8);
    rdchk("rel2_btn", A_BTN, 16'h0000);
    rd_clear("clr2_data", 16'h0004);
    irqchk("clr2_irq", 1'b0);

    // Bounce on key 0: runs of 2 never reach the 4-cycle threshold
    for (int k = 0; k < 5; k++) begin
      buttons = 4'b1110;
      cyc(2);
      buttons = 4'b1111;
      cyc(2);
      rdchk("bnc_btn", A_BTN, 16'h0000);
    end
    cyc(8);
    rdchk("bnc_btn_end", A_BTN, 16'h0000);
    rdchk("bnc_evt", A_EVT, 16'h0000);
    irqchk("bnc_irq", 1'b0);

    // Switch latency and access direction
    switches = 9'h1A5;
    cyc(1);
    rdchk("sw_1", A_SW, 16'h0000);
    cyc(1);
    rdchk("sw_2", A_SW, 16'h01A5);
    oe   = 1'b1;
    addr = A_SW;
    #1;
    expect_val("sw_wr_le", 16'h0000);
    observe({15'b0, le});
    expect_val("sw_wr_data", 16'h0000);
    observe(data_io);
    oe   = 1'b0;
    addr = 16'h1234;
    #1;
    expect_val("other_le", 16'h0000);
    observe({15'b0, le});
    expect_val("other_data", 16'h0000);
    observe(data_io);
    oe   = 1'b1;
    addr = 16'h0000;

    // Reset in the middle of a press discards the partial count
    buttons = 4'b1110;
    cyc(5);
    rdchk("mid_btn_pre", A_BTN, 16'h0000);
    reset = 1'b0;
    #1;
    rdchk("mid_btn_rst", A_BTN, 16'h0000);
    rdchk("mid_sw_rst", A_SW, 16'h0000);
    irqchk("mid_irq_rst", 1'b0);
    cyc(1);
    reset = 1'b1;
    expect_val("mid_btn_5", 16'h0000);
    cyc(5);
    rd(A_BTN, d, l);
    observe(d);
    expect_val("mid_btn_6", 16'h0001);
    cyc(1);
    rd(A_BTN, d, l);
    observe(d);
    rdchk("mid_evt", A_EVT, 16'h0001);
    irqchk("mid_irq", 1'b1);

    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed <none> required %h", e.tag, e.val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
